// File: rtl/speech_pkg.sv
// Shared types and the word-to-flash address table for the talking calculator speech path.
// The GAP state exists only when SPEECH_GAP_EN is defined.
package speech_pkg;

  typedef enum logic [4:0] {
    ZERO, ONE, TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE,
    PLUS, MINUS, TIMES, DIVIDE, EQUALS, POINT, NEGATIVE, ERROR
  } word_t;

  localparam int NUM_WORDS = 18;

  // Each word owns a 16 KiB flash slot; recordings grow slightly with the code.
  localparam logic [23:0] WORD_START [NUM_WORDS] = '{
    24'h000000, 24'h004000, 24'h008000, 24'h00C000, 24'h010000, 24'h014000,
    24'h018000, 24'h01C000, 24'h020000, 24'h024000, 24'h028000, 24'h02C000,
    24'h030000, 24'h034000, 24'h038000, 24'h03C000, 24'h040000, 24'h044000
  };

  localparam logic [23:0] WORD_END [NUM_WORDS] = '{
    24'h002FFF, 24'h00707F, 24'h00B0FF, 24'h00F17F, 24'h0131FF, 24'h01727F,
    24'h01B2FF, 24'h01F37F, 24'h0233FF, 24'h02747F, 24'h02B4FF, 24'h02F57F,
    24'h0335FF, 24'h03767F, 24'h03B6FF, 24'h03F77F, 24'h0437FF, 24'h04787F
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_PLAY
`ifdef SPEECH_GAP_EN
    , S_GAP
`endif
  } state_t;

endpackage

// File: rtl/speech_fifo.sv
// Word-code queue: synchronous push/pop with flush and occupancy count, async reset.
module speech_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [4:0]               push_data,
  output logic [4:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush wins over everything, so a same-cycle push is simply lost.
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/speech_sequencer.sv
// Plays queued calculator words through the audio controller one word at a time.
// Define SPEECH_GAP_EN to insert GAP_CYCLES of silence after every word.
module speech_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid,
  input  logic [4:0]                    push_word,
  output logic                          push_ready,
  input  logic                          flush,
  output logic [23:0]                   start_address,
  output logic [23:0]                   end_address,
  output logic                          play_start,
  input  logic                          play_finish,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          bad_word
);

  import speech_pkg::*;

  state_t     state;
  logic [4:0] cur_code;
  logic [4:0] fifo_head;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

`ifdef SPEECH_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_count;
`endif

  // A flushing cycle must not pop, otherwise a discarded word would still play.
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty && !flush;
  assign push_ready = !fifo_full;
  assign busy       = (state != S_IDLE) || !fifo_empty;

  speech_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_valid),
    .pop      (fifo_pop),
    .flush    (flush),
    .push_data(push_word),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cur_code      <= '0;
      start_address <= '0;
      end_address   <= '0;
      play_start    <= 1'b0;
      bad_word      <= 1'b0;
`ifdef SPEECH_GAP_EN
      gap_count     <= '0;
`endif
    end else begin
      bad_word <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            cur_code <= fifo_head;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cur_code < 5'(NUM_WORDS)) begin
            start_address <= WORD_START[cur_code];
            end_address   <= WORD_END[cur_code];
            play_start    <= 1'b1;
            state         <= S_LAUNCH;
          end else begin
            bad_word <= 1'b1;
            state    <= S_IDLE;
          end
        end
        // Hold the request until the controller drops its idle flag.
        S_LAUNCH: begin
          if (!play_finish) begin
            play_start <= 1'b0;
            state      <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (play_finish) begin
`ifdef SPEECH_GAP_EN
            gap_count <= '0;
            state     <= S_GAP;
`else
            state     <= S_IDLE;
`endif
          end
        end
`ifdef SPEECH_GAP_EN
        S_GAP: begin
          if (gap_count == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
          else gap_count <= gap_count + 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed bench for speech_sequencer with a simple audio controller model driven from tasks.
// Expectations follow SPEECH_GAP_EN when it is defined for the build.
module tb_speech_sequencer;

  localparam int DEPTH = 8;
  localparam int GAP   = 10;
`ifdef SPEECH_GAP_EN
  localparam int NEXT_LAUNCH = GAP + 3;
  localparam int GAP_WAIT    = GAP;
`else
  localparam int NEXT_LAUNCH = 3;
  localparam int GAP_WAIT    = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [4:0]  push_word;
  logic        push_ready;
  logic        flush;
  logic [23:0] start_address;
  logic [23:0] end_address;
  logic        play_start;
  logic        play_finish;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        bad_word;

  int n_compared   = 0;
  int n_mismatched = 0;

  speech_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_word    (push_word),
    .push_ready   (push_ready),
    .flush        (flush),
    .start_address(start_address),
    .end_address  (end_address),
    .play_start   (play_start),
    .play_finish  (play_finish),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .bad_word     (bad_word)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] code);
    push_valid = 1'b1;
    push_word  = code;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_play_start(output int cyc);
    cyc = 0;
    while (!play_start && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!play_start) cyc = -1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    if (busy) cyc = -1;
  endtask

  // Controller model: ack 2 cycles after the request, play for len cycles, go idle.
  task automatic serve_word(input int len);
    repeat (2) tick();
    play_finish = 1'b0;
    repeat (len) tick();
    play_finish = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; push_valid = 1'b0; push_word = '0; flush = 1'b0; play_finish = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b0;
    tick();
    n_compared++; if (fifo_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    n_compared++; if (push_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", push_ready); end
    n_compared++; if (play_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_play_start: got %b expected 0", play_start); end
    n_compared++; if (bad_word !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_bad_word: got %b expected 0", bad_word); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_compared++; if (start_address !== 24'h0) begin n_mismatched++; $display("[TB] FAIL reset_start: got %h expected 000000", start_address); end
    n_compared++; if (end_address !== 24'h0) begin n_mismatched++; $display("[TB] FAIL reset_end: got %h expected 000000", end_address); end
  endtask

  task automatic test_single_word();
    int cyc;
    push_one(5'd3);
    n_compared++; if (fifo_count !== 4'd1) begin n_mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", fifo_count); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_busy_queued: got %b expected 1", busy); end
    tick();
    n_compared++; if (play_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_early_start: got %b expected 0", play_start); end
    tick();
    n_compared++; if (play_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_start: got %b expected 1", play_start); end
    n_compared++; if (start_address !== 24'h00C000) begin n_mismatched++; $display("[TB] FAIL single_start_addr: got %h expected 00C000", start_address); end
    n_compared++; if (end_address !== 24'h00F17F) begin n_mismatched++; $display("[TB] FAIL single_end_addr: got %h expected 00F17F", end_address); end
    repeat (2) tick();
    n_compared++; if (play_start !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_start_level: got %b expected 1", play_start); end
    play_finish = 1'b0;
    tick();
    n_compared++; if (play_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_start_drop: got %b expected 0", play_start); end
    repeat (99) tick();
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_busy_play: got %b expected 1", busy); end
    play_finish = 1'b1;
    tick();
    repeat (GAP_WAIT) tick();
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  codes [4] = '{5'd1, 5'd10, 5'd2, 5'd14};
    logic [23:0] exp_s [4] = '{24'h004000, 24'h028000, 24'h008000, 24'h038000};
    logic [23:0] exp_e [4] = '{24'h00707F, 24'h02B4FF, 24'h00B0FF, 24'h03B6FF};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_word  = codes[i];
      tick();
    end
    push_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_play_start(cyc);
      if (k == 0) begin
        n_compared++; if (cyc < 0) begin n_mismatched++; $display("[TB] FAIL b2b_timeout word %0d: got %0d expected >=0", k, cyc); end
      end else begin
        n_compared++; if (cyc !== NEXT_LAUNCH) begin n_mismatched++; $display("[TB] FAIL b2b_latency word %0d: got %0d expected %0d", k, cyc, NEXT_LAUNCH); end
      end
      n_compared++; if (play_finish !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_start_during_play word %0d: got %b expected 1", k, play_finish); end
      n_compared++; if (start_address !== exp_s[k] || end_address !== exp_e[k]) begin n_mismatched++; $display("[TB] FAIL b2b_addr word %0d: got %h/%h expected %h/%h", k, start_address, end_address, exp_s[k], exp_e[k]); end
      n_compared++; if (fifo_count !== 4'(3 - k)) begin n_mismatched++; $display("[TB] FAIL b2b_count word %0d: got %0d expected %0d", k, fifo_count, 3 - k); end
      serve_word(20);
    end
    wait_idle(cyc);
    n_compared++; if (cyc < 0) begin n_mismatched++; $display("[TB] FAIL b2b_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int cyc;
    push_one(5'd0);
    wait_play_start(cyc);
    n_compared++; if (cyc < 0) begin n_mismatched++; $display("[TB] FAIL ovf_launch: got %0d expected >=0", cyc); end
    push_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_word = 5'(i);
      tick();
    end
    n_compared++; if (fifo_count !== 4'd8) begin n_mismatched++; $display("[TB] FAIL ovf_count_full: got %0d expected 8", fifo_count); end
    n_compared++; if (push_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_ready: got %b expected 0", push_ready); end
    push_word = 5'd9;
    tick();
    push_valid = 1'b0;
    n_compared++; if (fifo_count !== 4'd8) begin n_mismatched++; $display("[TB] FAIL ovf_count_drop: got %0d expected 8", fifo_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_compared++; if (fifo_count !== 4'd0 || push_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ovf_flush: got count=%0d ready=%b expected 0/1", fifo_count, push_ready); end
    play_finish = 1'b0;
    tick();
    play_finish = 1'b1;
    wait_idle(cyc);
    n_compared++; if (cyc < 0) begin n_mismatched++; $display("[TB] FAIL ovf_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_flush();
    int cyc;
    int starts;
    push_one(5'd1);
    wait_play_start(cyc);
    n_compared++; if (start_address !== 24'h004000 || end_address !== 24'h00707F) begin n_mismatched++; $display("[TB] FAIL flush_addr: got %h/%h expected 004000/00707F", start_address, end_address); end
    push_one(5'd2);
    push_one(5'd3);
    push_one(5'd4);
    n_compared++; if (fifo_count !== 4'd3) begin n_mismatched++; $display("[TB] FAIL flush_queued: got %0d expected 3", fifo_count); end
    play_finish = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_compared++; if (fifo_count !== 4'd0) begin n_mismatched++; $display("[TB] FAIL flush_count: got %0d expected 0", fifo_count); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_still_playing: got %b expected 1", busy); end
    repeat (5) tick();
    play_finish = 1'b1;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (play_start) starts++;
    end
    n_compared++; if (starts !== 0) begin n_mismatched++; $display("[TB] FAIL flush_no_restart: got %0d start cycles expected 0", starts); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_idle: got %b expected 0", busy); end
  endtask

  task automatic test_bad_word();
    int cyc;
    push_one(5'd31);
    tick();
    tick();
    n_compared++; if (bad_word !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bad31_pulse: got %b expected 1", bad_word); end
    n_compared++; if (start_address !== 24'h004000 || end_address !== 24'h00707F) begin n_mismatched++; $display("[TB] FAIL bad31_addr_held: got %h/%h expected 004000/00707F", start_address, end_address); end
    n_compared++; if (play_start !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bad31_no_play: got start=%b busy=%b expected 0/0", play_start, busy); end
    tick();
    n_compared++; if (bad_word !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bad31_one_cycle: got %b expected 0", bad_word); end
    push_one(5'd18);
    tick();
    tick();
    n_compared++; if (bad_word !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bad18_pulse: got %b expected 1", bad_word); end
    push_one(5'd17);
    wait_play_start(cyc);
    n_compared++; if (start_address !== 24'h044000 || end_address !== 24'h04787F) begin n_mismatched++; $display("[TB] FAIL last_word_addr: got %h/%h expected 044000/04787F", start_address, end_address); end
    n_compared++; if (bad_word !== 1'b0) begin n_mismatched++; $display("[TB] FAIL last_word_bad: got %b expected 0", bad_word); end
    serve_word(5);
    wait_idle(cyc);
    n_compared++; if (cyc < 0) begin n_mismatched++; $display("[TB] FAIL last_word_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_play();
    int cyc;
    int starts;
    push_one(5'd5);
    wait_play_start(cyc);
    push_one(5'd6);
    push_one(5'd7);
    play_finish = 1'b0;
    repeat (2) tick();
    n_compared++; if (fifo_count !== 4'd2) begin n_mismatched++; $display("[TB] FAIL rst_queued: got %0d expected 2", fifo_count); end
    #2 reset = 1'b1;
    #1;
    n_compared++; if (fifo_count !== 4'd0 || push_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_queue: got count=%0d ready=%b expected 0/1", fifo_count, push_ready); end
    n_compared++; if (busy !== 1'b0 || play_start !== 1'b0 || bad_word !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_flags: got busy=%b start=%b bad=%b expected 0/0/0", busy, play_start, bad_word); end
    n_compared++; if (start_address !== 24'h0 || end_address !== 24'h0) begin n_mismatched++; $display("[TB] FAIL rst_addr: got %h/%h expected 000000/000000", start_address, end_address); end
    play_finish = 1'b1;
    #2 reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (play_start || busy) starts++;
    end
    n_compared++; if (starts !== 0) begin n_mismatched++; $display("[TB] FAIL rst_stays_idle: got %0d active cycles expected 0", starts); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_bad_word();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
